// File: rtl/sram_mem_responder.sv
// Memory-stage responder that splits a 32-bit load/store into two 16-bit SRAM accesses.
// It holds the pipeline (ready=0) until both halves have completed.
module sram_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [15:0]            sram_dq_in,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_nextState;
    logic [3:0]               r_waitCnt;
    logic [3:0]               w_nextCnt;
    logic                     r_isRead;
    logic [SRAM_ADDR_W-2:0]   r_addr;
    logic [31:0]              r_wdata;
    logic [31:0]              r_readData;
    logic                     w_req;
    logic                     w_lastCycle;
    logic                     w_unused;

    assign w_req       = mem_read | mem_write;
    assign w_lastCycle = (r_waitCnt == LP_LAST);
    assign read_data   = r_readData;
    assign w_unused    = &{1'b0, address[31:SRAM_ADDR_W+1], address[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_waitCnt  <= 4'd0;
            r_isRead   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_readData <= 32'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextCnt;
            // A simultaneous read and write request is served as a read.
            if (r_state == IDLE && w_req) begin
                r_addr   <= address[SRAM_ADDR_W:2];
                r_wdata  <= write_data;
                r_isRead <= mem_read;
            end
            if (r_isRead && w_lastCycle && r_state == LOW) begin
                r_readData[15:0] <= sram_dq_in;
            end
            if (r_isRead && w_lastCycle && r_state == HIGH) begin
                r_readData[31:16] <= sram_dq_in;
            end
        end
    end

    // The write strobe is released in the last cycle of each phase so the data is held past the strobe.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_waitCnt;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (r_state)
            IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    w_nextState = LOW;
                    w_nextCnt   = 4'd0;
                end
            end
            LOW: begin
                sram_addr = {r_addr, 1'b0};
                if (!r_isRead) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[15:0];
                    sram_we_n   = w_lastCycle;
                end
                if (w_lastCycle) begin
                    w_nextState = HIGH;
                    w_nextCnt   = 4'd0;
                end else begin
                    w_nextCnt = r_waitCnt + 4'd1;
                end
            end
            HIGH: begin
                sram_addr = {r_addr, 1'b1};
                if (!r_isRead) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = r_wdata[31:16];
                    sram_we_n   = w_lastCycle;
                end
                if (w_lastCycle) begin
                    w_nextState = DONE;
                    w_nextCnt   = 4'd0;
                end else begin
                    w_nextCnt = r_waitCnt + 4'd1;
                end
            end
            DONE: begin
                ready       = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder: default timing instance plus a WAIT_CYCLES=4 instance,
// each attached to a small behavioural SRAM.
module tb_sram_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        preloadEn;

    logic        memRead, memWrite;
    logic [31:0] address, writeData, readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDqIn, sramDqOut;
    logic        sramDqOe, sramWeN;

    logic        memRead4;
    logic [31:0] address4, readData4;
    logic        ready4;
    logic [17:0] sramAddr4;
    logic [15:0] sramDqIn4, sramDqOut4;
    logic        sramDqOe4, sramWeN4;

    logic [15:0] sramMem  [0:255];
    logic [15:0] sramMem4 [0:255];

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    sram_mem_responder #(.WAIT_CYCLES(2), .SRAM_ADDR_W(18)) dut (
        .clk(clk), .rst(rst),
        .mem_read(memRead), .mem_write(memWrite),
        .address(address), .write_data(writeData),
        .read_data(readData), .ready(ready),
        .sram_addr(sramAddr), .sram_dq_in(sramDqIn), .sram_dq_out(sramDqOut),
        .sram_dq_oe(sramDqOe), .sram_we_n(sramWeN)
    );

    sram_mem_responder #(.WAIT_CYCLES(4), .SRAM_ADDR_W(18)) dut4 (
        .clk(clk), .rst(rst),
        .mem_read(memRead4), .mem_write(1'b0),
        .address(address4), .write_data(32'd0),
        .read_data(readData4), .ready(ready4),
        .sram_addr(sramAddr4), .sram_dq_in(sramDqIn4), .sram_dq_out(sramDqOut4),
        .sram_dq_oe(sramDqOe4), .sram_we_n(sramWeN4)
    );

    // Behavioural SRAMs: asynchronous read, write on a rising edge while the strobe is low and the bus is driven.
    assign sramDqIn  = sramMem[sramAddr[7:0]];
    assign sramDqIn4 = sramMem4[sramAddr4[7:0]];

    always @(posedge clk) begin
        if (preloadEn) begin
            for (int i = 0; i < 256; i++) sramMem[i] <= 16'h0000;
            sramMem[0] <= 16'h1111;
            sramMem[1] <= 16'h2222;
            sramMem[2] <= 16'h3333;
            sramMem[3] <= 16'h4444;
            sramMem[5] <= 16'hAAAA;
        end else if (sramDqOe && !sramWeN) begin
            sramMem[sramAddr[7:0]] <= sramDqOut;
        end
    end

    always @(posedge clk) begin
        if (preloadEn) begin
            for (int i = 0; i < 256; i++) sramMem4[i] <= 16'h0000;
            sramMem4[8] <= 16'h5678;
            sramMem4[9] <= 16'h1234;
        end else if (sramDqOe4 && !sramWeN4) begin
            sramMem4[sramAddr4[7:0]] <= sramDqOut4;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        preloadEn = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = 32'd0;
        writeData = 32'd0;
        memRead4  = 1'b0;
        address4  = 32'd0;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_we_n", 32'(sramWeN), 32'd1);
        checkOutput("rst_oe", 32'(sramDqOe), 32'd0);
        checkOutput("rst_dq_out", 32'(sramDqOut), 32'd0);
        checkOutput("rst_addr", 32'(sramAddr), 32'd0);
        checkOutput("rst_rdata", readData, 32'd0);
        tick();
        rst       = 1'b1;
        preloadEn = 1'b0;
        @(negedge clk);
        checkOutput("release_we_n", 32'(sramWeN), 32'd1);
        checkOutput("release_ready", 32'(ready), 32'd1);
        tick();

        // Write 0xDEADBEEF to 0x104
        memWrite  = 1'b1;
        address   = 32'h0000_0104;
        writeData = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("wr_ready_c%0d", c), 32'(ready), 32'(c == 5));
            checkOutput($sformatf("wr_addr_c%0d", c), 32'(sramAddr),
                        (c == 0 || c == 5) ? 32'h0 : (c <= 2 ? 32'h82 : 32'h83));
            checkOutput($sformatf("wr_dq_c%0d", c), 32'(sramDqOut),
                        (c == 0 || c == 5) ? 32'h0 : (c <= 2 ? 32'hBEEF : 32'hDEAD));
            checkOutput($sformatf("wr_oe_c%0d", c), 32'(sramDqOe), 32'(c >= 1 && c <= 4));
            checkOutput($sformatf("wr_we_n_c%0d", c), 32'(sramWeN), 32'(!(c == 1 || c == 3)));
            tick();
        end
        memWrite = 1'b0;
        @(negedge clk);
        checkOutput("wr_idle_ready", 32'(ready), 32'd1);
        checkOutput("wr_mem_lo", 32'(sramMem[8'h82]), 32'hBEEF);
        checkOutput("wr_mem_hi", 32'(sramMem[8'h83]), 32'hDEAD);
        checkOutput("wr_rdata_kept", readData, 32'd0);
        tick();

        // Read back 0x104
        memRead = 1'b1;
        address = 32'h0000_0104;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rd_ready_c%0d", c), 32'(ready), 32'(c == 5));
            checkOutput($sformatf("rd_we_n_c%0d", c), 32'(sramWeN), 32'd1);
            checkOutput($sformatf("rd_oe_c%0d", c), 32'(sramDqOe), 32'd0);
            checkOutput($sformatf("rd_addr_c%0d", c), 32'(sramAddr),
                        (c == 0 || c == 5) ? 32'h0 : (c <= 2 ? 32'h82 : 32'h83));
            if (c == 3) checkOutput("rd_rdata_lo_only", readData, 32'h0000_BEEF);
            if (c == 5) checkOutput("rd_rdata", readData, 32'hDEAD_BEEF);
            tick();
        end
        memRead = 1'b0;
        @(negedge clk);
        checkOutput("rd_rdata_hold", readData, 32'hDEAD_BEEF);
        tick();

        // Back-to-back reads of 0x0 then 0x4 with the request held across DONE
        memRead = 1'b1;
        address = 32'h0000_0000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_ready_c%0d", c), 32'(ready), 32'(c == 5 || c == 11));
            if (c == 5)  checkOutput("b2b_rdata0", readData, 32'h2222_1111);
            if (c == 11) checkOutput("b2b_rdata1", readData, 32'h4444_3333);
            tick();
            if (c == 5) address = 32'h0000_0004;
        end
        memRead = 1'b0;
        @(negedge clk);
        checkOutput("b2b_idle_ready", 32'(ready), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("b2b_no_dup_addr", 32'(sramAddr), 32'd0);
        checkOutput("b2b_no_dup_ready", 32'(ready), 32'd1);
        tick();

        // Reset asserted in the first HIGH cycle of a write to 0x8
        memWrite  = 1'b1;
        address   = 32'h0000_0008;
        writeData = 32'hCAFE_F00D;
        tick();
        tick();
        @(negedge clk);
        checkOutput("rstmid_low_addr", 32'(sramAddr), 32'h4);
        tick();
        rst      = 1'b0;
        memWrite = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_we_n", 32'(sramWeN), 32'd1);
        checkOutput("rstmid_oe", 32'(sramDqOe), 32'd0);
        checkOutput("rstmid_addr", 32'(sramAddr), 32'd0);
        checkOutput("rstmid_ready", 32'(ready), 32'd1);
        checkOutput("rstmid_rdata", readData, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_release_we_n", 32'(sramWeN), 32'd1);
        checkOutput("rstmid_mem_lo", 32'(sramMem[4]), 32'hF00D);
        checkOutput("rstmid_mem_hi", 32'(sramMem[5]), 32'hAAAA);
        tick();

        // Read and write together behave as a read only
        memRead   = 1'b1;
        memWrite  = 1'b1;
        address   = 32'h0000_0104;
        writeData = 32'h1234_5678;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("both_ready_c%0d", c), 32'(ready), 32'(c == 5));
            checkOutput($sformatf("both_we_n_c%0d", c), 32'(sramWeN), 32'd1);
            checkOutput($sformatf("both_oe_c%0d", c), 32'(sramDqOe), 32'd0);
            if (c == 5) checkOutput("both_rdata", readData, 32'hDEAD_BEEF);
            tick();
        end
        memRead  = 1'b0;
        memWrite = 1'b0;
        @(negedge clk);
        checkOutput("both_mem_lo", 32'(sramMem[8'h82]), 32'hBEEF);
        checkOutput("both_mem_hi", 32'(sramMem[8'h83]), 32'hDEAD);
        tick();

        // WAIT_CYCLES=4 read of 0x10
        memRead4 = 1'b1;
        address4 = 32'h0000_0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("w4_ready_c%0d", c), 32'(ready4), 32'(c == 9));
            checkOutput($sformatf("w4_we_n_c%0d", c), 32'(sramWeN4), 32'd1);
            if (c == 9) checkOutput("w4_rdata", readData4, 32'h1234_5678);
            tick();
        end
        memRead4 = 1'b0;
        @(negedge clk);
        checkOutput("w4_idle_ready", 32'(ready4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/sram_mem_responder.md
SRAM_MEM_RESPONDER -- requirements
Module: sram_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM cycles per 16-bit half-access; legal range 2..15.
REQ-002 Parameter SRAM_ADDR_W, default 18, external SRAM address width in 16-bit halfwords.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  read request from memory stage; level, held until ready.
REQ-006 mem_write  input  1  write request from memory stage; level, held until ready.
REQ-007 address  input  32  byte address (ALU result); bits [1:0] ignored.
REQ-008 write_data  input  32  store data (Rm value).
REQ-009 read_data  output  32  load data; valid while ready=1 after a read.
REQ-010 ready  output  1  high = no pending work / access complete; low = pipeline must freeze.
REQ-011 sram_addr  output  SRAM_ADDR_W  halfword address = {address[SRAM_ADDR_W:2], half}.
REQ-012 sram_dq_in  input  16  data from SRAM.
REQ-013 sram_dq_out  output  16  data to SRAM.
REQ-014 sram_dq_oe  output  1  high = drive sram_dq_out onto SRAM bus.
REQ-015 sram_we_n  output  1  active-low SRAM write strobe.

Function
REQ-016 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-017 IDLE: if mem_read or mem_write at edge, latch address, write_data, op (read if mem_read=1, else write), clear wait counter, go LOW.
REQ-018 mem_read and mem_write both high: treated as read; no SRAM write occurs.
REQ-019 LOW: half=0; hold WAIT_CYCLES cycles; then go HIGH with counter cleared.
REQ-020 HIGH: half=1; hold WAIT_CYCLES cycles; then go DONE.
REQ-021 DONE: one cycle; then unconditionally IDLE (new request accepted only from IDLE).
REQ-022 Write phases: sram_dq_oe=1 all cycles; sram_dq_out = latched data [15:0] in LOW, [31:16] in HIGH; sram_we_n=0 in all but last cycle of phase, 1 in last cycle.
REQ-023 Read phases: sram_dq_oe=0, sram_we_n=1; sram_dq_in captured into read_data[15:0] at edge ending last LOW cycle, [31:16] at edge ending last HIGH cycle.
REQ-024 Outside LOW/HIGH: sram_dq_oe=0, sram_we_n=1, sram_dq_out=0, sram_addr=0.
REQ-025 ready (combinational): IDLE -> ~(mem_read|mem_write); LOW/HIGH -> 0; DONE -> 1.
REQ-026 Latency: request first seen in IDLE at cycle 0 -> ready=1 in cycle 1+2*WAIT_CYCLES (cycle 5 at default).
REQ-027 Back-to-back requests: request held high across DONE->IDLE yields ready=0 in that IDLE cycle and a new transaction; no request lost or duplicated while caller drops it after ready.
REQ-028 Request deasserted mid-transaction: transaction still completes, DONE pulse still issued.
REQ-029 read_data holds last read value until overwritten by next read; writes do not modify it.
REQ-030 Wait counter 4 bits, saturating-free: resets to 0 on each phase entry, never wraps within a phase.

Reset
REQ-031 rst=0 at any time, including mid-phase: state=IDLE, counter=0, read_data=0, latched address/data=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-032 While rst=0 ready follows IDLE rule; no SRAM write strobe is generated on reset release.

Verification
REQ-033 Write 0xDEADBEEF to address 0x00000104 -> LOW: sram_addr=0x00082, dq_out=0xBEEF, we_n=0 cycle 1, 1 cycle 2; HIGH: sram_addr=0x00083, dq_out=0xDEAD; ready=1 in cycle 5.
REQ-034 Read address 0x00000104, SRAM model returns 0xBEEF/0xDEAD -> read_data=0xDEADBEEF, ready=1 in cycle 5, we_n=1 throughout.
REQ-035 Two reads held back-to-back (0x0, 0x4) -> ready pattern 0,0,0,0,0,1,0,0,0,0,0,1; both values correct.
REQ-036 rst=0 during HIGH of a write -> next cycle we_n=1, dq_oe=0, state IDLE; SRAM upper half unwritten; ready=1 with no request.
REQ-037 mem_read=mem_write=1 -> read sequence only, we_n never 0.
REQ-038 WAIT_CYCLES=4 read -> ready=1 in cycle 9; we_n stays 1.
